// File: rtl/example2_bus_sequencer.sv
// Round-robin owner sequencer for the example2 two-source output bus, with turnaround cycle.
// Optional per-owner burst cap is enabled by defining EXAMPLE2_BURST_LIMIT_EN.
module example2_bus_sequencer #(
    parameter int unsigned WIDTH     = 21,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             done_a,
    input  logic             done_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        TURN  = 2'd3
    } state_t;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("example2_bus_sequencer: MAX_BURST must be in 1..255");
    end

    state_t           state_q, state_d;
    logic             last_a_q, last_a_d;
    logic             sel_q, sel_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic             busy_q, busy_d;
    logic             bus_valid_q, bus_valid_d;
    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             burst_end;

`ifdef EXAMPLE2_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        burst_end = (cnt_q == BURST_LAST);
    end
`else
    always_comb begin
        burst_end = 1'b0;
    end
`endif

    always_comb begin
        state_d     = state_q;
        last_a_d    = last_a_q;
        sel_d       = sel_q;
        bus_out_d   = bus_out_q;
        bus_valid_d = 1'b0;
`ifdef EXAMPLE2_BURST_LIMIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef EXAMPLE2_BURST_LIMIT_EN
                cnt_d = '0;
`endif
                // On a tie the requester that did not own the bus last wins.
                if (req_a && (!req_b || !last_a_q)) begin
                    state_d  = OWN_A;
                    sel_d    = 1'b1;
                    last_a_d = 1'b1;
                end else if (req_b) begin
                    state_d  = OWN_B;
                    sel_d    = 1'b0;
                    last_a_d = 1'b0;
                end
            end
            OWN_A: begin
                if (req_a) begin
                    bus_valid_d = 1'b1;
                    bus_out_d   = data_a;
                end
                if (done_a || !req_a || burst_end) begin
                    state_d = TURN;
                end else begin
`ifdef EXAMPLE2_BURST_LIMIT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            OWN_B: begin
                if (req_b) begin
                    bus_valid_d = 1'b1;
                    bus_out_d   = data_b;
                end
                if (done_b || !req_b || burst_end) begin
                    state_d = TURN;
                end else begin
`ifdef EXAMPLE2_BURST_LIMIT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Grants and busy are registered copies of the next state, so they track state_q exactly.
        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_a_q    <= 1'b0;
            sel_q       <= 1'b0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            busy_q      <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_out_q   <= '0;
`ifdef EXAMPLE2_BURST_LIMIT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_a_q    <= last_a_d;
            sel_q       <= sel_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            busy_q      <= busy_d;
            bus_valid_q <= bus_valid_d;
            bus_out_q   <= bus_out_d;
`ifdef EXAMPLE2_BURST_LIMIT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign bus_valid = bus_valid_q;
    assign bus_out   = bus_out_q;

endmodule

// File: tb/tb_example2_bus_sequencer.sv
// Directed, table-driven bench for example2_bus_sequencer with hand-written multi-cycle sequences.
module tb_example2_bus_sequencer;

    localparam int unsigned W = 21;

    logic         clk = 1'b0;
    logic         reset, req_a, req_b, done_a, done_b;
    logic [W-1:0] data_a, data_b;
    logic         gnt_a, gnt_b, sel, bus_valid, busy;
    logic [W-1:0] bus_out;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    example2_bus_sequencer #(.WIDTH(W), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .done_a(done_a), .done_b(done_b),
        .data_a(data_a), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
        .bus_out(bus_out), .bus_valid(bus_valid), .busy(busy)
    );

    typedef struct {
        logic         rst, ra, rb, da, db;
        logic [W-1:0] dat_a, dat_b;
        logic         ga, gb, sl, bv;
        logic [W-1:0] bo;
        logic         bz;
    } vec_t;

    function automatic vec_t mk(input logic rst, ra, rb, da, db,
                                input logic [W-1:0] dat_a, dat_b,
                                input logic ga, gb, sl, bv,
                                input logic [W-1:0] bo, input logic bz);
        vec_t v;
        v.rst = rst; v.ra = ra; v.rb = rb; v.da = da; v.db = db;
        v.dat_a = dat_a; v.dat_b = dat_b;
        v.ga = ga; v.gb = gb; v.sl = sl; v.bv = bv; v.bo = bo; v.bz = bz;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (started) check("no_double_grant", {31'd0, gnt_a & gnt_b}, 32'd0);
    end

    localparam logic [W-1:0] A1 = 21'h0A001, A2 = 21'h0A002, A3 = 21'h0A003, A4 = 21'h0A004;
    localparam logic [W-1:0] A5 = 21'h1FFFFF, A6 = 21'h0A006, A7 = 21'h0A007;
    localparam logic [W-1:0] B1 = 21'h0B001, B2 = 21'h0B002, B3 = 21'h155555, B4 = 21'h0B004;

    vec_t tbl[24];

    initial begin
        int abeats;
        bit seen;

        // rst ra rb da db  dat_a dat_b | ga gb sel bv  bo  busy
        tbl[0]  = mk(1,1,1,0,0, 0,  0,   0,0,0,0, 0,  0);
        tbl[1]  = mk(1,1,1,0,0, 0,  0,   0,0,0,0, 0,  0);
        tbl[2]  = mk(1,1,1,0,0, 0,  0,   0,0,0,0, 0,  0);
        tbl[3]  = mk(0,1,1,0,0, 0,  0,   1,0,1,0, 0,  1);
        tbl[4]  = mk(0,1,1,0,0, A1, 0,   1,0,1,1, A1, 1);
        tbl[5]  = mk(0,1,1,1,0, A2, 0,   0,0,1,1, A2, 1);
        tbl[6]  = mk(0,1,1,0,0, A3, 0,   0,0,1,0, A2, 0);
        tbl[7]  = mk(0,1,1,0,0, 0,  0,   0,1,0,0, A2, 1);
        tbl[8]  = mk(0,1,1,0,0, 0,  B1,  0,1,0,1, B1, 1);
        tbl[9]  = mk(0,1,1,0,1, 0,  B2,  0,0,0,1, B2, 1);
        tbl[10] = mk(0,1,1,0,0, 0,  0,   0,0,0,0, B2, 0);
        tbl[11] = mk(0,1,1,0,0, 0,  0,   1,0,1,0, B2, 1);
        tbl[12] = mk(0,1,1,0,1, A4, 0,   1,0,1,1, A4, 1);
        tbl[13] = mk(0,1,1,0,1, A5, 0,   1,0,1,1, A5, 1);
        tbl[14] = mk(0,0,1,0,0, A6, 0,   0,0,1,0, A5, 1);
        tbl[15] = mk(0,1,0,0,0, 0,  0,   0,0,1,0, A5, 0);
        tbl[16] = mk(0,1,0,0,0, 0,  0,   1,0,1,0, A5, 1);
        tbl[17] = mk(0,1,0,1,0, A7, 0,   0,0,1,1, A7, 1);
        tbl[18] = mk(0,0,0,0,0, 0,  0,   0,0,1,0, A7, 0);
        tbl[19] = mk(0,0,0,0,0, 0,  0,   0,0,1,0, A7, 0);
        tbl[20] = mk(0,0,1,1,0, 0,  0,   0,1,0,0, A7, 1);
        tbl[21] = mk(0,0,1,0,0, 0,  B3,  0,1,0,1, B3, 1);
        tbl[22] = mk(1,0,1,0,0, 0,  B4,  0,0,0,0, 0,  0);
        tbl[23] = mk(0,0,0,0,0, 0,  0,   0,0,0,0, 0,  0);

        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
        data_a = '0; data_b = '0;

        for (int i = 0; i < 24; i++) begin
            reset = tbl[i].rst; req_a = tbl[i].ra; req_b = tbl[i].rb;
            done_a = tbl[i].da; done_b = tbl[i].db;
            data_a = tbl[i].dat_a; data_b = tbl[i].dat_b;
            tick();
            started = 1'b1;
            check($sformatf("v%0d_gnt_a", i), {31'd0, gnt_a}, {31'd0, tbl[i].ga});
            check($sformatf("v%0d_gnt_b", i), {31'd0, gnt_b}, {31'd0, tbl[i].gb});
            check($sformatf("v%0d_sel", i), {31'd0, sel}, {31'd0, tbl[i].sl});
            check($sformatf("v%0d_bus_valid", i), {31'd0, bus_valid}, {31'd0, tbl[i].bv});
            check($sformatf("v%0d_bus_out", i), {11'd0, bus_out}, {11'd0, tbl[i].bo});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bz});
        end

        // Single A burst of 4 beats ending on done_a (last owner is B after the reset above).
        req_a = 1'b1; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0; data_a = '0;
        tick();
        check("burst_grant", {31'd0, gnt_a}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            data_a = 21'h10000 + 21'(k);
            done_a = (k == 4);
            tick();
            check($sformatf("burst_beat%0d_valid", k), {31'd0, bus_valid}, 32'd1);
            check($sformatf("burst_beat%0d_data", k), {11'd0, bus_out}, 32'h10000 + 32'(k));
            check($sformatf("burst_beat%0d_gnt_a", k), {31'd0, gnt_a}, (k < 4) ? 32'd1 : 32'd0);
        end
        req_a = 1'b0; done_a = 1'b0;
        check("burst_turn_busy", {31'd0, busy}, 32'd1);
        tick();
        check("burst_idle_busy", {31'd0, busy}, 32'd0);
        check("burst_idle_valid", {31'd0, bus_valid}, 32'd0);

        // Long A ownership with B waiting.
        req_a = 1'b1;
        tick();
        check("long_grant_a", {31'd0, gnt_a}, 32'd1);
        req_b = 1'b1;
        abeats = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data_a = 21'h20000 + 21'(i);
            tick();
            if (gnt_b) begin
                seen = 1'b1;
                break;
            end
            if (bus_valid) abeats++;
        end
`ifdef EXAMPLE2_BURST_LIMIT_EN
        check("limit_a_beats", 32'(abeats), 32'd8);
        check("limit_b_granted", {31'd0, seen}, 32'd1);
`else
        check("nolimit_a_beats", 32'(abeats), 32'd20);
        check("nolimit_b_not_granted", {31'd0, seen}, 32'd0);
        check("nolimit_a_holds", {31'd0, gnt_a}, 32'd1);
        req_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt_b) begin
                seen = 1'b1;
                break;
            end
        end
        check("nolimit_b_after_drop", {31'd0, seen}, 32'd1);
`endif
        req_a = 1'b0; req_b = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_idle", {31'd0, busy}, 32'd0);

        // Reset asserted during A beat 3.
        req_a = 1'b1;
        tick();
        check("rst_mid_grant", {31'd0, gnt_a}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            data_a = 21'h30000 + 21'(k);
            reset = (k == 3);
            tick();
        end
        check("rst_mid_gnt_a", {31'd0, gnt_a}, 32'd0);
        check("rst_mid_valid", {31'd0, bus_valid}, 32'd0);
        check("rst_mid_bus_out", {11'd0, bus_out}, 32'd0);
        reset = 1'b0; req_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst_after%0d_valid", k), {31'd0, bus_valid}, 32'd0);
            check($sformatf("rst_after%0d_gnt_a", k), {31'd0, gnt_a}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
